// File: rtl/array_flatten_stream_if.sv
// array_flatten_stream_if
//   Bundles the frame-input and beat-output handshakes of array_flatten_stream.
//
//   Handshake rules (both channels): a transfer happens on a rising clk edge
//   where valid && ready. A producer that raises valid keeps its payload
//   stable until that transfer. Ready may depend on the consumer's state
//   but never on valid.
//
//   in          : ROWS x COLS array of BIT_WIDTH-bit elements, in[i][j]
//   in_col_fast : flattening order for the frame (0 row-fastest, 1 col-fastest)
//   in_valid    : frame valid
//   in_ready    : block can take a frame this cycle
//   out_data    : one beat, lane l at [l*BIT_WIDTH +: BIT_WIDTH]
//   out_valid   : beat valid
//   out_ready   : consumer takes the beat
//   out_last    : final beat of the frame
//
//   Modports: slave = the flattener, master = the environment around it.
interface array_flatten_stream_if #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 4
);
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in;
  logic                                     in_col_fast;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [LANES*BIT_WIDTH-1:0]               out_data;
  logic                                     out_valid;
  logic                                     out_ready;
  logic                                     out_last;

  modport slave (
    input  in, in_col_fast, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in, in_col_fast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/array_flatten_stream.sv
// array_flatten_stream
//   Captures a whole ROWS x COLS array in one handshake, then streams it out
//   as BEATS = ROWS*COLS/LANES beats of LANES elements each. The flattening
//   order is chosen per frame:
//     in_col_fast=0 : k = j*ROWS + i   (row index fastest)
//     in_col_fast=1 : k = i*COLS + j   (column index fastest)
//   Beat b carries elements b*LANES .. b*LANES+LANES-1, element b*LANES+l in
//   lane l. A new frame can be taken on the accepted last beat, so
//   back-to-back frames stream with no idle cycle.
//
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     bus           : array_flatten_stream_if.slave (frame in, beats out)
//     dbg_state     : FSM state (0 = IDLE, 1 = SEND)
//     dbg_beat_cnt  : index of the beat currently presented
module array_flatten_stream #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 4,
  localparam int N        = ROWS * COLS,
  localparam int BEATS    = N / LANES,
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  array_flatten_stream_if.slave bus,
  output logic                  dbg_state,
  output logic [CNT_W-1:0]      dbg_beat_cnt
);

  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("array_flatten_stream: LANES must divide ROWS*COLS");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                                   state, state_nxt;
  logic [CNT_W-1:0]                         beat_cnt, beat_cnt_nxt;
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] frame_buf;
  logic                                     order_q;
  logic                                     capture;
  logic                                     is_last;
  logic                                     beat_accept;

  // Both flattenings are pure wiring of the buffer; the latched order picks one.
  logic [N-1:0][BIT_WIDTH-1:0]              flat_r, flat_c;
  logic [BEATS-1:0][LANES*BIT_WIDTH-1:0]    beat_view;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      assign flat_r[j*ROWS + i] = frame_buf[i][j];
      assign flat_c[i*COLS + j] = frame_buf[i][j];
    end
  end

  // Element k sits at bits [k*BIT_WIDTH +:], so reshaping the flat vector
  // into BEATS words puts element b*LANES+l into lane l of word b.
  assign beat_view = order_q ? flat_c : flat_r;

  assign is_last     = (state == SEND) && (beat_cnt == CNT_W'(BEATS - 1));
  assign beat_accept = (state == SEND) && bus.out_ready;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign bus.in_ready  = (state == IDLE) || (bus.out_ready && is_last);
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = is_last;
  assign bus.out_data  = (state == SEND) ? beat_view[beat_cnt] : '0;

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          capture      = 1'b1;
          beat_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (beat_accept) begin
          if (is_last) begin
            beat_cnt_nxt = '0;
            if (bus.in_valid) begin
              capture   = 1'b1;
              state_nxt = SEND;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_buf <= '0;
      order_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (capture) begin
        frame_buf <= bus.in;
        order_q   <= bus.in_col_fast;
      end
    end
  end

endmodule

// File: tb/tb_array_flatten_stream.sv
module tb_array_flatten_stream;
  localparam int BW    = 4;
  localparam int R     = 2;
  localparam int C     = 3;
  localparam int L     = 2;
  localparam int CNT_W = 2;
  localparam int W     = L * BW + 1;  // {last, data}

  logic             clk;
  logic             rst;
  logic             dbg_state;
  logic [CNT_W-1:0] dbg_beat_cnt;

  array_flatten_stream_if #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C), .LANES(L)) bus ();

  array_flatten_stream #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C), .LANES(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        bus.in[i][j] = BW'(i * 3 + j);
  endtask

  task automatic set_all_f();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        bus.in[i][j] = 4'hF;
  endtask

  task automatic push(input logic last, input logic [L*BW-1:0] data);
    exp_q.push_back({last, data});
  endtask

  // Ramp frame, row-fastest order: elements 0,3,1,4,2,5.
  task automatic push_ramp_order0();
    push(1'b0, 8'h30);
    push(1'b0, 8'h41);
    push(1'b1, 8'h52);
  endtask

  // Ramp frame, column-fastest order: elements 0..5.
  task automatic push_ramp_order1();
    push(1'b0, 8'h10);
    push(1'b0, 8'h32);
    push(1'b1, 8'h54);
  endtask

  // Presents a ramp frame for one edge; returns #1 after the capture edge.
  task automatic capture_ramp(input logic order);
    set_ramp();
    bus.in_col_fast = order;
    bus.in_valid    = 1'b1;
    cyc();
    bus.in_valid    = 1'b0;
  endtask

  // monitor: pops and compares every beat accepted on the following edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {23'd0, bus.out_last, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("beat_data", {24'd0, bus.out_data}, {24'd0, e[L*BW-1:0]});
        check("beat_last", {31'd0, bus.out_last}, {31'd0, e[W-1]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.in          = '0;
    bus.in_col_fast = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // reset state
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_state",     {31'd0, dbg_state},     32'd0);

    // order 0, out_ready held high
    bus.out_ready = 1'b1;
    push_ramp_order0();
    capture_ramp(1'b0);
    check("o0_first_valid", {31'd0, bus.out_valid}, 32'd1);
    check("o0_first_cnt",   {30'd0, dbg_beat_cnt},  32'd0);
    cyc();
    cyc();
    check("o0_last_beat",   {31'd0, bus.out_last},  32'd1);
    check("o0_last_ready",  {31'd0, bus.in_ready},  32'd1);
    cyc();
    check("o0_idle_valid",  {31'd0, bus.out_valid}, 32'd0);

    // order 1
    push_ramp_order1();
    capture_ramp(1'b1);
    cyc();
    cyc();
    cyc();
    check("o1_idle_valid",  {31'd0, bus.out_valid}, 32'd0);

    // backpressure on beat 1; a competing frame must be ignored
    push_ramp_order0();
    capture_ramp(1'b0);
    cyc();
    bus.out_ready = 1'b0;
    set_all_f();
    bus.in_col_fast = 1'b1;
    bus.in_valid    = 1'b1;
    for (int s = 0; s < 3; s++) begin
      check("bp_hold_data",  {24'd0, bus.out_data},  32'h41);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    check("bp_last_data", {24'd0, bus.out_data}, 32'h52);
    cyc();
    check("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // back-to-back: second frame offered on the accepted last beat
    push_ramp_order0();
    capture_ramp(1'b0);
    cyc();
    cyc();
    set_all_f();
    bus.in_col_fast = 1'b1;
    bus.in_valid    = 1'b1;
    push(1'b0, 8'hFF);
    push(1'b0, 8'hFF);
    push(1'b1, 8'hFF);
    check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    check("b2b_data",  {24'd0, bus.out_data},  32'hFF);
    check("b2b_cnt",   {30'd0, dbg_beat_cnt},  32'd0);
    cyc();
    cyc();
    cyc();
    check("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // reset after beat 0 drops the rest of the frame
    push_ramp_order0();
    capture_ramp(1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    push(1'b0, 8'h30);
    push(1'b0, 8'h41);
    check("mrst_valid",    {31'd0, bus.out_valid}, 32'd0);
    check("mrst_data",     {24'd0, bus.out_data},  32'd0);
    check("mrst_in_ready", {31'd0, bus.in_ready},  32'd1);
    exp_q.delete();
    push_ramp_order1();
    capture_ramp(1'b1);
    check("mrst_new_cnt",  {30'd0, dbg_beat_cnt},  32'd0);
    check("mrst_new_data", {24'd0, bus.out_data},  32'h10);
    cyc();
    cyc();
    cyc();
    check("mrst_idle_valid", {31'd0, bus.out_valid}, 32'd0);

    cyc();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_flatten_stream.md
# array_flatten_stream

Streaming successor to the combinational 3D-to-1D array flattener. It captures a whole ROWS x COLS array of BIT_WIDTH-bit elements in one valid/ready handshake. It then emits the array over several beats of LANES elements each, in a flattening order selected per frame. It sits between array-producing compute blocks and narrower downstream datapaths such as memory writers and serial links.

## Interface
Parameters:
- BIT_WIDTH, 4: bits per element.
- ROWS, 8: first array dimension.
- COLS, 8: second array dimension.
- LANES, 4: elements per output beat. Must divide ROWS*COLS; any other value is an elaboration error.
- Derived: BEATS = ROWS*COLS/LANES. CNT_W = max(1, $clog2(BEATS)).

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous active-high reset.
- in, input, [BIT_WIDTH-1:0] x [ROWS-1:0][COLS-1:0]: array to capture.
- in_col_fast, input, 1: order select, sampled with the frame. 0 = row index fastest; 1 = column index fastest.
- in_valid, input, 1: the frame on `in` and `in_col_fast` is valid.
- in_ready, output, 1: the block can accept a frame this cycle.
- out_data, output, LANES*BIT_WIDTH: current beat. Lane l is at bits [l*BIT_WIDTH +: BIT_WIDTH].
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the consumer accepts the beat.
- out_last, output, 1: the current beat is beat BEATS-1 of the frame.

## Operation
Flat element index k for in[i][j]:
- in_col_fast=0: k = j*ROWS + i. This is the same layout as the existing combinational flattener.
- in_col_fast=1: k = i*COLS + j.

Beat b carries elements k = b*LANES .. b*LANES+LANES-1. Element b*LANES+l goes in lane l.

State machine:
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: register `in` into the frame buffer, latch in_col_fast, clear beat_cnt, go to SEND.
- SEND:
  - out_valid=1. out_data = beat beat_cnt of the buffer in the latched order.
  - out_last = (beat_cnt == BEATS-1).
  - Beat accepted (out_valid && out_ready), not last: beat_cnt += 1, stay in SEND.
  - Beat accepted and last, no in_valid: go to IDLE.
  - Beat accepted and last, with in_valid the same cycle: capture the new frame, clear beat_cnt, stay in SEND. There is no bubble.

Handshake and data rules:
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). It is combinational from state and out_ready; there is no path from in_valid.
- out_data, out_valid and out_last hold stable while out_valid && !out_ready.
- While in SEND and not on an accepted last beat, in_valid is ignored and the buffer is not overwritten.
- out_data is a mux of registered state only. There is no combinational path from `in`.

Reset:
- state=IDLE, beat_cnt=0, buffer=0, order=0.
- out_valid=0, out_last=0 (BEATS>1), out_data=0, in_ready=1 from the first cycle after reset.
- Reset mid-frame drops the remaining beats. A capture or accept in the reset cycle has no effect.

Edge case BEATS=1: every beat has out_last=1, and frames stream one per cycle.

## Timing
- Capture edge to the first out_valid: 1 cycle.
- A frame occupies exactly BEATS accepted beats.
- Sustained throughput with out_ready held at 1 and in_valid held at 1: one frame per BEATS cycles, 100% output utilisation.
- Each out_ready stall cycle adds exactly one cycle to the frame.
- All outputs except in_ready are registered-state functions.

## Test plan
Common setup: BIT_WIDTH=4, ROWS=2, COLS=3, LANES=2 (BEATS=3), in[i][j] = i*3+j.
- Order 0, out_ready=1: capture -> beats 8'h30, 8'h41, 8'h52 on consecutive cycles starting 1 cycle after capture; out_last only on 8'h52; in_ready high on the last beat.
- Order 1, out_ready=1: capture -> beats 8'h10, 8'h32, 8'h54.
- Backpressure: out_ready low for 3 cycles during beat 1 -> 8'h41 held stable with out_valid=1; in_ready=0; a new in_valid is ignored and the buffer is unchanged.
- Back-to-back: second frame (all elements 4'hF, order 1) presented with in_valid during the accepted last beat -> next cycle out_data=8'hFF, beat_cnt=0, no idle cycle.
- Reset mid-frame: rst asserted after beat 0 -> next cycle out_valid=0, out_data=0, in_ready=1; the next frame starts at beat 0.
- Build with LANES=4 (does not divide 6): elaboration fails.
